fifo_wr_arbiter: RTL and testbench

Write-side arbiter that shares one `sync_fifo` instance among NREQ independent producers. Each cycle it picks at most one requesting producer in round-robin order, forwards that producer's word to the FIFO write port one cycle later, and throttles grants against FIFO occupancy so the FIFO never overflows. It sits directly in front of `sync_fifo` (`wren`/`write_data`/`fifo_full`/`room_avail`). The read side stays with the consumer.

---
 rtl/fifo_arb_pkg.sv | 13 +
 rtl/fifo_wr_arbiter_if.sv | 36 +++
 rtl/fifo_wr_arbiter_rr_pick.sv | 27 ++
 rtl/fifo_wr_arbiter.sv | 147 ++++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/fifo_arb_pkg.sv
// rtl/fifo_arb_pkg.sv - shared constants and state type for the FIFO write arbiter
package fifo_arb_pkg;

  localparam int FIFO_PTR  = 4;
  localparam int FIFO_DATA = 32;
  localparam int FIFO_NREQ = 4;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_LOCK = 1'b1
  } arb_state_e;

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// rtl/fifo_wr_arbiter_if.sv - producer request bus plus sync_fifo write-port signals
interface fifo_wr_arbiter_if #(
  parameter int NREQ = 4,
  parameter int DATA = 32,
  parameter int PTR  = 4
);

  logic [NREQ-1:0]      req;
  logic [NREQ*DATA-1:0] req_data;
  logic [NREQ-1:0]      gnt;
  logic                 fifo_wren;
  logic [DATA-1:0]      fifo_wdata;
  logic                 fifo_full;
  logic [PTR:0]         fifo_room_avail;

  modport master (
    input  req,
    input  req_data,
    output gnt,
    output fifo_wren,
    output fifo_wdata,
    input  fifo_full,
    input  fifo_room_avail
  );

  modport slave (
    output req,
    output req_data,
    input  gnt,
    input  fifo_wren,
    input  fifo_wdata,
    output fifo_full,
    output fifo_room_avail
  );

endinterface

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// rtl/fifo_wr_arbiter_rr_pick.sv - combinational round-robin picker, search starts after last_gnt
module rr_pick #(
  parameter int NREQ = 4,
  parameter int LG   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [LG-1:0]   last_gnt,
  output logic [NREQ-1:0] winner
);

  logic found;

  // Outer loop is search order, inner loop keeps every bit-select constant.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      for (int j = 0; j < NREQ; j++) begin
        if (!found && req[j] && (j == ((int'(last_gnt) + k) % NREQ))) begin
          winner[j] = 1'b1;
          found     = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - round-robin write arbiter sharing one sync_fifo among NREQ producers
// FIFO_ARB_BURST_EN: when defined, a winner keeps the FIFO for up to BURST granted beats.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NREQ  = FIFO_NREQ,
  parameter int DATA  = FIFO_DATA,
  parameter int PTR   = FIFO_PTR,
  parameter int BURST = 4
) (
  input  logic              clk,
  input  logic              rst,
  fifo_wr_arbiter_if.master bus
);

  localparam int LG = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int BW = PTR + 1;

  if (NREQ < 2 || NREQ > 8 || BURST < 1 || BURST > 2**PTR) begin : g_bad_param
    $error("fifo_wr_arbiter: parameter out of range");
  end

  logic            fifo_wren_q, fifo_wren_d;
  logic [DATA-1:0] fifo_wdata_q, fifo_wdata_d;
  logic [LG-1:0]   last_gnt_q, last_gnt_d;
  logic            space_ok;
  logic [NREQ-1:0] eligible;
  logic [NREQ-1:0] pick;
  logic [NREQ-1:0] gnt;
  logic [LG-1:0]   win_idx;
  logic [DATA-1:0] win_data;

  // The write already registered for this cycle still needs a slot.
  assign space_ok = !bus.fifo_full && (bus.fifo_room_avail > {{PTR{1'b0}}, fifo_wren_q});

`ifdef FIFO_ARB_BURST_EN
  arb_state_e      state_q, state_d;
  logic [LG-1:0]   owner_q, owner_d;
  logic [BW-1:0]   beat_q, beat_d;
  logic [NREQ-1:0] owner_mask;

  always_comb begin
    owner_mask = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (owner_q == LG'(i)) owner_mask[i] = 1'b1;
    end
  end

  assign eligible = (state_q == ARB_LOCK) ? (bus.req & owner_mask) : bus.req;

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    beat_d  = beat_q;
    case (state_q)
      ARB_IDLE: begin
        if (|gnt && BURST > 1) begin
          state_d = ARB_LOCK;
          owner_d = win_idx;
          beat_d  = {{(BW-1){1'b0}}, 1'b1};
        end
      end
      ARB_LOCK: begin
        // A stall for lack of space keeps the lock; a dropped request releases it.
        if (|gnt) begin
          if (beat_q + 1'b1 == BW'(BURST)) begin
            state_d = ARB_IDLE;
            beat_d  = '0;
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end else if (!(|(bus.req & owner_mask))) begin
          state_d = ARB_IDLE;
          beat_d  = '0;
        end
      end
      default: begin
        state_d = ARB_IDLE;
        beat_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ARB_IDLE;
      owner_q <= '0;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      beat_q  <= beat_d;
    end
  end
`else
  assign eligible = bus.req;
`endif

  rr_pick #(
    .NREQ (NREQ),
    .LG   (LG)
  ) u_rr_pick (
    .req      (eligible & {NREQ{space_ok}}),
    .last_gnt (last_gnt_q),
    .winner   (pick)
  );

  assign gnt     = rst ? '0 : pick;
  assign bus.gnt = gnt;

  always_comb begin
    win_idx  = '0;
    win_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (pick[i]) begin
        win_idx  = LG'(i);
        win_data = bus.req_data[i*DATA +: DATA];
      end
    end
  end

  always_comb begin
    fifo_wren_d  = |gnt;
    fifo_wdata_d = fifo_wdata_q;
    last_gnt_d   = last_gnt_q;
    if (|gnt) begin
      fifo_wdata_d = win_data;
      last_gnt_d   = win_idx;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fifo_wren_q  <= 1'b0;
      fifo_wdata_q <= '0;
      last_gnt_q   <= LG'(NREQ - 1);
    end else begin
      fifo_wren_q  <= fifo_wren_d;
      fifo_wdata_q <= fifo_wdata_d;
      last_gnt_q   <= last_gnt_d;
    end
  end

  assign bus.fifo_wren  = fifo_wren_q;
  assign bus.fifo_wdata = fifo_wdata_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb/tb_fifo_wr_arbiter.sv - directed scoreboard bench for fifo_wr_arbiter (FIFO_ARB_BURST_EN aware)
module tb_fifo_wr_arbiter;

  localparam int NREQ  = 4;
  localparam int DATA  = 32;
  localparam int PTR   = 4;
  localparam int BURST = 4;
  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fifo_wr_arbiter_if #(.NREQ(NREQ), .DATA(DATA), .PTR(PTR)) bus ();

  fifo_wr_arbiter #(
    .NREQ  (NREQ),
    .DATA  (DATA),
    .PTR   (PTR),
    .BURST (BURST)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int              pass_cnt  = 0;
  int              total_cnt = 0;
  logic [DATA-1:0] exp_q[$];
  logic [DATA-1:0] pdata[NREQ];
  int              m_last, m_cnt, m_owner, m_beat;
  logic            m_wren, m_lock;
  bit              room_ovr;
  int              wren_seen, overflow_seen, gnt0_seen;
  logic [3:0]      g_seen;
  logic            g_wren;
  logic [3:0]      rr_exp[5];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [3:0] mpick(input logic [3:0] m, input int last);
    for (int k = 1; k <= NREQ; k++) begin
      if (m[(last + k) % NREQ]) return 4'b0001 << ((last + k) % NREQ);
    end
    return 4'b0000;
  endfunction

  // One cycle: sample mid-cycle against the model, then advance model at the edge.
  task automatic tick();
    logic [3:0] elig, eg;
    logic       sp;
    int         widx;
    if (!room_ovr) bus.fifo_room_avail = 5'(DEPTH - m_cnt);
    #1;
    sp   = !bus.fifo_full && (bus.fifo_room_avail > {4'b0000, m_wren});
    elig = bus.req;
`ifdef FIFO_ARB_BURST_EN
    if (m_lock) elig = bus.req & (4'b0001 << m_owner);
`endif
    eg = rst ? 4'b0000 : mpick(elig & {4{sp}}, m_last);
    g_seen = bus.gnt;
    g_wren = bus.fifo_wren;
    check("gnt", bus.gnt, eg);
    check("fifo_wren", bus.fifo_wren, m_wren);
    if (m_wren && exp_q.size() > 0) check("fifo_wdata", bus.fifo_wdata, exp_q.pop_front());
    if (bus.fifo_wren === 1'b1) begin
      wren_seen++;
      if (bus.fifo_room_avail == 0) overflow_seen++;
    end
    if (bus.gnt[0] === 1'b1) gnt0_seen++;
    widx = 0;
    for (int i = 0; i < NREQ; i++) if (eg[i]) widx = i;
    if (|eg) exp_q.push_back(pdata[widx]);
    @(posedge clk);
    if (rst) begin
      m_wren = 1'b0; m_last = NREQ - 1; m_cnt = 0;
      m_lock = 1'b0; m_beat = 0; m_owner = 0;
      exp_q.delete();
    end else begin
      if (m_wren) m_cnt++;
`ifdef FIFO_ARB_BURST_EN
      if (!m_lock) begin
        if (|eg && BURST > 1) begin m_lock = 1'b1; m_owner = widx; m_beat = 1; end
      end else if (|eg) begin
        m_beat++;
        if (m_beat == BURST) begin m_lock = 1'b0; m_beat = 0; end
      end else if (!bus.req[m_owner]) begin
        m_lock = 1'b0; m_beat = 0;
      end
`endif
      m_wren = |eg;
      if (|eg) m_last = widx;
    end
    @(negedge clk);
  endtask

  task automatic rst_pulse();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < NREQ; i++) pdata[i] = 32'h1000 + i;
    bus.req_data        = {pdata[3], pdata[2], pdata[1], pdata[0]};
    bus.req             = 4'b1111;
    bus.fifo_full       = 1'b0;
    bus.fifo_room_avail = 5'd16;
    room_ovr = 1'b0;
    m_wren = 1'b0; m_last = NREQ - 1; m_cnt = 0; m_lock = 1'b0; m_beat = 0; m_owner = 0;
    wren_seen = 0; overflow_seen = 0; gnt0_seen = 0;
    rr_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

    // Reset held three cycles with all producers requesting
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_gnt", g_seen, 4'b0000);
      check("rst_wdata", bus.fifo_wdata, 32'h0);
    end
    rst = 1'b0;

`ifndef FIFO_ARB_BURST_EN
    for (int i = 0; i < 5; i++) begin
      tick();
      check("rr_seq", g_seen, rr_exp[i]);
    end
    tick();
`else
    // Burst: owner 0 for 4 beats with a 2-cycle full stall, then owner 1
    tick();
    check("first_gnt", g_seen, 4'b0001);
    rst_pulse();
    bus.req = 4'b0011;
    gnt0_seen = 0;
    tick(); tick();
    bus.fifo_full = 1'b1;
    tick();
    check("burst_stall", g_seen, 4'b0000);
    tick();
    check("burst_stall", g_seen, 4'b0000);
    bus.fifo_full = 1'b0;
    tick();
    check("burst_resume", g_seen, 4'b0001);
    tick();
    check("burst_beat4", g_seen, 4'b0001);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("burst_owner1", g_seen, 4'b0010);
    end
    check("burst_total0", gnt0_seen, 4);
    bus.req = 4'b0000;
    tick();
`endif

    // Near-full throttle on producer 2
    rst_pulse();
    bus.req = 4'b0100;
    room_ovr = 1'b1;
    bus.fifo_room_avail = 5'd1;
    tick();
    check("nf_grant", g_seen, 4'b0100);
    tick();
    check("nf_inflight_block", g_seen, 4'b0000);
    tick();
    check("nf_regrant", g_seen, 4'b0100);
    bus.fifo_full = 1'b1;
    bus.fifo_room_avail = 5'd16;
    tick();
    tick();
    check("full_block", g_seen, 4'b0000);
    bus.fifo_full = 1'b0;
    room_ovr = 1'b0;

    // Fill to depth from producer 0 with no reads
    bus.req = 4'b0000;
    rst_pulse();
    bus.req = 4'b0001;
    wren_seen = 0;
    overflow_seen = 0;
    for (int i = 0; i < 20; i++) tick();
    check("fill_wren_pulses", wren_seen, 16);
    check("fill_no_overflow", overflow_seen, 0);
    check("fill_gnt_after", g_seen, 4'b0000);

    // Reset in the middle of a stream
    bus.req = 4'b0000;
    rst_pulse();
    bus.req = 4'b0011;
    tick(); tick();
    rst = 1'b1;
    tick();
    check("midrst_gnt", g_seen, 4'b0000);
    check("midrst_wren_inflight", g_wren, 1'b1);
    rst = 1'b0;
    tick();
    check("midrst_wren_cleared", g_wren, 1'b0);
    check("midrst_first_gnt", g_seen, 4'b0001);
    tick();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
